clk_div_prog: RTL and testbench
===============================

// Module: clk_div_prog
// PURPOSE
//  Programmable integer clock divider. Successor to the fixed ripple divide-by-8.
//  - Fully synchronous: one counter on clk, no derived clocks, so nothing is clocked off a divided net.
//  - Produces a registered divided-clock level (clk_out) and a one-cycle strobe (tick) per output period.
//  - The divide ratio is set at runtime. Changes take effect only at a period boundary, so there are no glitches.
//  - Used as the timebase for the self-test sequencers.
// PARAMETERS
//  DIV_W        8   width of divide ratio and internal counter
//  DEFAULT_DIV  8   ratio after reset; legal range 2..2**DIV_W-1
// PORTS
//  clk       in   1      system clock
//  rst       in   1      asynchronous, active-high reset
//  en        in   1      run enable; low parks the divider
//  sync_clr  in   1      restart period now (phase align), sampled when en=1
//  div_val   in   DIV_W  requested divide ratio N
//  load      in   1      1-cycle strobe: capture div_val into pending register
//  clk_out   out  1      divided clock level, registered
//  tick      out  1      1-cycle pulse on the first cycle of each period (clk_out rise)
//  pend      out  1      high while a loaded ratio awaits the period boundary
//  cfg_err   out  1      sticky; set when a loaded div_val < 2 (clamped to 2)
// BEHAVIOUR
//  State
//   - n_act: active ratio. n_pend: pending ratio, with pend as its valid flag.
//   - cnt: period counter, 0..n_act-1.
//   - H = n_act - (n_act>>1), i.e. ceil(n_act/2).
//  Reset (async, rst=1)
//   - cnt=DEFAULT_DIV-1, n_act=DEFAULT_DIV, n_pend=DEFAULT_DIV.
//   - clk_out=0, tick=0, pend=0, cfg_err=0.
//  Load (any cycle, independent of en)
//   - load=1: n_pend <= max(div_val,2); pend <= 1.
//   - div_val<2 also sets cfg_err. cfg_err is cleared only by rst.
//   - A second load before the boundary overwrites n_pend; last load wins.
//  Run (en=1), per clk edge
//   - wrap = (cnt==n_act-1) | sync_clr.
//   - On wrap:
//     - cnt <= 0.
//     - If pend: n_act <= n_pend, pend <= 0.
//     - load and wrap in the same cycle: the new value goes to n_pend and pend stays 1.
//       It applies at the next boundary, not this one.
//   - Otherwise: cnt <= cnt+1.
//   - clk_out <= (cnt_next < H_next), where H_next is computed from the n_act in force for cnt_next.
//   - tick <= (cnt_next == 0).
//   - Both outputs correspond to cnt in the same cycle, with no extra latency.
//  Waveform
//   - Period is n_act clk cycles; clk_out is high for ceil(N/2) cycles, then low.
//   - Even N gives exactly 50% duty. Odd N is high one cycle longer than low.
//  Park (en=0)
//   - cnt <= n_act-1, clk_out <= 0, tick <= 0.
//   - Any pending ratio is applied immediately: n_act <= n_pend, pend <= 0.
//   - After en rises, the first edge is a wrap: tick=1, clk_out=1.
//  sync_clr
//   - Truncates the current period; the next cycle is cnt=0 with tick=1.
//   - sync_clr held high gives tick every cycle with clk_out=1. This is legal; the caller must not depend on it.
//  Reset mid-period
//   - All outputs drop immediately (async) and the ratio reverts to DEFAULT_DIV.
//  Width
//   - cnt and compares are DIV_W bits, unsigned. N=2**DIV_W-1 must not overflow.
// TESTING
//  1. rst, then en=1, defaults:
//     - clk_out is 4 high / 4 low, repeating.
//     - tick fires every 8 cycles, in the first cycle after en.
//  2. load div_val=5 mid-period:
//     - pend=1 until the wrap; the current 8-cycle period completes.
//     - Then 3 high / 2 low; pend=0.
//  3. load div_val=1:
//     - cfg_err=1 and the ratio is clamped to 2.
//     - clk_out toggles every cycle; tick every 2 cycles.
//  4. sync_clr at cnt=2 with N=8:
//     - Next cycle tick=1 and the period restarts, with no short-high glitch.
//  5. Drop en mid-high, then raise it:
//     - clk_out=0 and tick=0 while parked.
//     - The first cycle after en rises has tick=1, clk_out=1.
//  6. Assert rst mid-period with N=5 loaded:
//     - Outputs go to 0 asynchronously.
//     - After release the divider runs at N=8 and cfg_err=0.

Source files
------------

// File: rtl/clk_div_prog.sv
// Programmable integer clock divider: registered clk_out level and a tick at each period start.
// Outputs track the counter with no extra latency; ratio changes only apply at a period boundary or while parked.
module clk_div_prog #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sync_clr,
    input  logic [DIV_W-1:0] div_val,
    input  logic             load,
    output logic             clk_out,
    output logic             tick,
    output logic             pend,
    output logic             cfg_err
);

    localparam logic [DIV_W-1:0] DEF_N = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] n_act;
    logic [DIV_W-1:0] n_pend;

    logic [DIV_W-1:0] n_sel;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] n_act_nxt;
    logic [DIV_W-1:0] h_nxt;
    logic             wrap;
    logic             consume;

    always_comb begin
        n_sel     = pend ? n_pend : n_act;
        wrap      = (cnt == n_act - ONE) | sync_clr;
        cnt_nxt   = cnt + ONE;
        n_act_nxt = n_act;
        consume   = 1'b0;
        if (!en) begin
            // Parking lands on the last count so the first enabled edge is a wrap.
            n_act_nxt = n_sel;
            cnt_nxt   = n_sel - ONE;
            consume   = pend;
        end else if (wrap) begin
            n_act_nxt = n_sel;
            cnt_nxt   = '0;
            consume   = pend;
        end
        h_nxt = n_act_nxt - (n_act_nxt >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= DEF_N - ONE;
            n_act   <= DEF_N;
            n_pend  <= DEF_N;
            pend    <= 1'b0;
            cfg_err <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            n_act   <= n_act_nxt;
            clk_out <= en & (cnt_nxt < h_nxt);
            tick    <= en & (cnt_nxt == '0);
            // A load coinciding with a boundary is held for the following one.
            if (load) begin
                n_pend <= (div_val < TWO) ? TWO : div_val;
                pend   <= 1'b1;
                if (div_val < TWO)
                    cfg_err <= 1'b1;
            end else if (consume) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed vector bench for clk_div_prog: table of per-cycle stimulus/expectations plus reset sequences.
module tb_clk_div_prog;

    typedef struct {
        logic       en;
        logic       sc;
        logic       ld;
        logic [7:0] dv;
        logic [3:0] exp;   // {clk_out, tick, pend, cfg_err}
    } vec_t;

    logic       clk      = 1'b0;
    logic       rst      = 1'b1;
    logic       en       = 1'b0;
    logic       sync_clr = 1'b0;
    logic       load     = 1'b0;
    logic [7:0] div_val  = 8'd0;
    logic       clk_out;
    logic       tick;
    logic       pend;
    logic       cfg_err;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    clk_div_prog #(.DIV_W(8), .DEFAULT_DIV(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (sync_clr),
        .div_val  (div_val),
        .load     (load),
        .clk_out  (clk_out),
        .tick     (tick),
        .pend     (pend),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    function automatic void add(logic e, logic s, logic l, logic [7:0] d,
                                logic co, logic tk, logic pd, logic er);
        vec_t v;
        v.en  = e;
        v.sc  = s;
        v.ld  = l;
        v.dv  = d;
        v.exp = {co, tk, pd, er};
        vecs.push_back(v);
    endfunction

    task automatic check(string nm, logic [3:0] exp);
        logic [3:0] act;
        act = {clk_out, tick, pend, cfg_err};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: clk_out/tick/pend/cfg_err got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Default N=8: 4 high / 4 low, tick on the first enabled edge.
        for (int i = 0; i < 16; i++)
            add(1, 0, 0, 0, (i % 8) < 4, (i % 8) == 0, 0, 0);
        // Load 5 mid-period: current 8-cycle period completes, then 3 high / 2 low.
        add(1, 0, 0, 0, 1, 1, 0, 0);
        add(1, 0, 1, 5, 1, 0, 1, 0);
        add(1, 0, 0, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 1, 0);
        for (int p = 0; p < 2; p++) begin
            add(1, 0, 0, 0, 1, 1, 0, 0);
            add(1, 0, 0, 0, 1, 0, 0, 0);
            add(1, 0, 0, 0, 1, 0, 0, 0);
            add(1, 0, 0, 0, 0, 0, 0, 0);
            add(1, 0, 0, 0, 0, 0, 0, 0);
        end
        // Load 1 on the wrap cycle: clamps to 2, sets cfg_err, held until the next boundary.
        add(1, 0, 1, 1, 1, 1, 1, 1);
        add(1, 0, 0, 0, 1, 0, 1, 1);
        add(1, 0, 0, 0, 1, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 0, 0, 1, 1);
        for (int p = 0; p < 3; p++) begin
            add(1, 0, 0, 0, 1, 1, 0, 1);
            add(1, 0, 0, 0, 0, 0, 0, 1);
        end
        // Back to N=8, then sync_clr at cnt=2 and held sync_clr.
        add(1, 0, 1, 8, 1, 1, 1, 1);
        add(1, 0, 0, 0, 0, 0, 1, 1);
        add(1, 0, 0, 0, 1, 1, 0, 1);
        add(1, 0, 0, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 1, 0, 0, 1);
        add(1, 1, 0, 0, 1, 1, 0, 1);
        add(1, 0, 0, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1);
        add(1, 1, 0, 0, 1, 1, 0, 1);
        add(1, 1, 0, 0, 1, 1, 0, 1);
        add(1, 0, 0, 0, 1, 0, 0, 1);
        // Park mid-high, load 3 while parked (applied immediately), then resume.
        add(0, 0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 1, 3, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1, 1, 0, 1);
        add(1, 0, 0, 0, 1, 0, 0, 1);
        add(1, 0, 0, 0, 0, 0, 0, 1);
        add(1, 0, 0, 0, 1, 1, 0, 1);

        #12;
        check("reset_state", 4'b0000);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            en       = vecs[i].en;
            sync_clr = vecs[i].sc;
            load     = vecs[i].ld;
            div_val  = vecs[i].dv;
            step();
            check($sformatf("row%0d", i), vecs[i].exp);
        end
        sync_clr = 1'b0;

        // Async reset mid-period with N=5 pending.
        en      = 1'b1;
        load    = 1'b1;
        div_val = 8'd5;
        step();
        load    = 1'b0;
        div_val = 8'd0;
        check("pre_rst_pending", 4'b1011);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_drop", 4'b0000);
        step();
        check("rst_held", 4'b0000);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            check($sformatf("post_rst%0d", i), {(i % 8) < 4, (i % 8) == 0, 2'b00});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
